// File: rtl/debouncer_multi.sv
// Multi-channel key debouncer: per-key synchroniser, glitch filter and
// press / release / long-press (with optional auto-repeat) event strobes.
module debouncer_multi #(
  parameter int CHANNELS       = 4,
  parameter int CLK_FREQ_MHZ   = 150,
  parameter int GLITCH_TIME_NS = 100,
  parameter int KEY_ACTIVE_LOW = 0,
  parameter int HOLD_TIME_US   = 500000,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_TIME_US = 100000
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_stb_o,
  output logic [CHANNELS-1:0] release_stb_o,
  output logic [CHANNELS-1:0] hold_stb_o
);

  localparam int G_RAW      = GLITCH_TIME_NS * CLK_FREQ_MHZ / 1000;
  localparam int H_RAW      = HOLD_TIME_US * CLK_FREQ_MHZ;
  localparam int R_RAW      = REPEAT_TIME_US * CLK_FREQ_MHZ;
  localparam int GLITCH_CYC = (G_RAW < 1) ? 1 : G_RAW;
  localparam int HOLD_CYC   = (H_RAW < 1) ? 1 : H_RAW;
  localparam int REPEAT_CYC = (R_RAW < 1) ? 1 : R_RAW;
  localparam int GCNT_W     = $clog2(GLITCH_CYC + 1);
  localparam int HOLD_W     = $clog2(HOLD_CYC + 1);
  localparam int REP_W      = $clog2(REPEAT_CYC + 1);
  // One hold counter serves both the first-hold and the repeat phase.
  localparam int HCNT_W     = (HOLD_W > REP_W) ? HOLD_W : REP_W;

  localparam logic [GCNT_W-1:0] G_LAST = GCNT_W'(GLITCH_CYC - 1);
  localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(HOLD_CYC - 1);
  localparam logic [HCNT_W-1:0] R_LAST = HCNT_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_HOLD = 2'd1,
    S_REPEAT    = 2'd2,
    S_DONE      = 2'd3
  } hold_state_t;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic              w_raw;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic [GCNT_W-1:0] r_gcnt;
    logic              r_press;
    logic              r_release;
    logic              r_hold;
    logic [HCNT_W-1:0] r_hcnt;
    logic [HCNT_W-1:0] w_hcnt_nxt;
    logic              w_differ;
    logic              w_toggle;
    logic              w_rise;
    logic              w_fall;
    logic              w_hold_fire;
    hold_state_t       r_state;
    hold_state_t       w_state_nxt;

    // Polarity is normalised before the synchroniser so reset means "released".
    assign w_raw    = (KEY_ACTIVE_LOW != 0) ? ~key_i[ch] : key_i[ch];
    assign w_differ = (r_sync2 != r_level);
    assign w_toggle = w_differ && (r_gcnt == G_LAST);
    assign w_rise   = w_toggle && !r_level;
    assign w_fall   = w_toggle && r_level;

    // Two-flop synchroniser for the asynchronous key.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= w_raw;
        r_sync2 <= r_sync1;
      end
    end

    // Glitch filter: level flips only after GLITCH_CYC consecutive differing samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_level   <= 1'b0;
        r_gcnt    <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_rise;
        r_release <= w_fall;
        if (w_toggle) begin
          r_level <= ~r_level;
          r_gcnt  <= '0;
        end else if (w_differ) begin
          r_gcnt <= r_gcnt + GCNT_W'(1);
        end else begin
          r_gcnt <= '0;
        end
      end
    end

    // Hold FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_state <= S_IDLE;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    // Hold FSM next-state logic; a falling level always wins.
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        S_IDLE:      if (w_rise) w_state_nxt = S_WAIT_HOLD;
        S_WAIT_HOLD: begin
          if (w_fall)                w_state_nxt = S_IDLE;
          else if (r_hcnt == H_LAST) w_state_nxt = (REPEAT_EN != 0) ? S_REPEAT : S_DONE;
        end
        S_REPEAT:    if (w_fall) w_state_nxt = S_IDLE;
        S_DONE:      if (w_fall) w_state_nxt = S_IDLE;
        default:     w_state_nxt = S_IDLE;
      endcase
    end

    // Hold FSM outputs: strobe decision and next hold-counter value.
    always_comb begin
      w_hold_fire = 1'b0;
      w_hcnt_nxt  = r_hcnt;
      case (r_state)
        S_WAIT_HOLD: begin
          if (r_hcnt == H_LAST) begin
            w_hold_fire = !w_fall;
            // Without repeat the counter parks at its terminal value.
            w_hcnt_nxt  = (REPEAT_EN != 0) ? '0 : r_hcnt;
          end else begin
            w_hcnt_nxt = r_hcnt + HCNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (r_hcnt == R_LAST) begin
            w_hold_fire = !w_fall;
            w_hcnt_nxt  = '0;
          end else begin
            w_hcnt_nxt = r_hcnt + HCNT_W'(1);
          end
        end
        S_DONE:  w_hcnt_nxt = r_hcnt;
        default: w_hcnt_nxt = '0;
      endcase
      if (!r_level || w_fall) w_hcnt_nxt = '0;
    end

    // Hold counter and registered hold strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_hcnt <= '0;
        r_hold <= 1'b0;
      end else begin
        r_hcnt <= w_hcnt_nxt;
        r_hold <= w_hold_fire;
      end
    end

    assign level_o[ch]       = r_level;
    assign press_stb_o[ch]   = r_press;
    assign release_stb_o[ch] = r_release;
    assign hold_stb_o[ch]    = r_hold;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: three configurations side by side, checked every
// cycle against a timestamp-based behavioural model plus literal expectations.
module tb_debouncer_multi;

  localparam int NI = 3;      // instances: A repeat, B no repeat, C active-low
  localparam int NC = 4;
  localparam int G  = 15;     // 100 ns at 150 MHz
  localparam int H  = 150;    // 1 us
  localparam int R  = 150;    // 1 us
  localparam int REP [NI]  = '{1, 0, 1};
  localparam int ALOW [NI] = '{0, 0, 1};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] pk  [NI];    // logical "pressed" per key
  logic [NC-1:0] kin [NI];    // physical key pins
  logic [NC-1:0] lvl [NI];
  logic [NC-1:0] prs [NI];
  logic [NC-1:0] rel [NI];
  logic [NC-1:0] hld [NI];

  int tests = 0;
  int fails = 0;
  int ncyc  = 0;

  // model state
  int m_s1 [NI][NC];
  int m_s2 [NI][NC];
  int m_lvl [NI][NC];
  int m_run [NI][NC];
  int m_age [NI][NC];
  logic [NC-1:0] e_lvl [NI];
  logic [NC-1:0] e_prs [NI];
  logic [NC-1:0] e_rel [NI];
  logic [NC-1:0] e_hld [NI];

  // DUT event counters
  int ev_p [NI][NC];
  int ev_r [NI][NC];
  int ev_h [NI][NC];

  always #5 clk = ~clk;

  assign kin[0] = pk[0];
  assign kin[1] = pk[1];
  assign kin[2] = ~pk[2];

  debouncer_multi #(.CHANNELS(NC), .CLK_FREQ_MHZ(150), .GLITCH_TIME_NS(100),
    .KEY_ACTIVE_LOW(0), .HOLD_TIME_US(1), .REPEAT_EN(1), .REPEAT_TIME_US(1)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(kin[0]), .level_o(lvl[0]),
    .press_stb_o(prs[0]), .release_stb_o(rel[0]), .hold_stb_o(hld[0]));

  debouncer_multi #(.CHANNELS(NC), .CLK_FREQ_MHZ(150), .GLITCH_TIME_NS(100),
    .KEY_ACTIVE_LOW(0), .HOLD_TIME_US(1), .REPEAT_EN(0), .REPEAT_TIME_US(1)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(kin[1]), .level_o(lvl[1]),
    .press_stb_o(prs[1]), .release_stb_o(rel[1]), .hold_stb_o(hld[1]));

  debouncer_multi #(.CHANNELS(NC), .CLK_FREQ_MHZ(150), .GLITCH_TIME_NS(100),
    .KEY_ACTIVE_LOW(1), .HOLD_TIME_US(1), .REPEAT_EN(1), .REPEAT_TIME_US(1)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(kin[2]), .level_o(lvl[2]),
    .press_stb_o(prs[2]), .release_stb_o(rel[2]), .hold_stb_o(hld[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, ncyc, act, exp);
    end
  endtask

  // One clock edge of the model. Key samples reach the filter two edges late;
  // a level change needs G consecutive filter samples differing from the level;
  // hold strobes fire when the press age reaches H (+ n*R with repeat).
  task automatic model_step();
    int ks;
    for (int p = 0; p < NI; p++) begin
      for (int c = 0; c < NC; c++) begin
        e_prs[p][c] = 1'b0;
        e_rel[p][c] = 1'b0;
        e_hld[p][c] = 1'b0;
        if (!rst_n) begin
          m_s1[p][c] = 0; m_s2[p][c] = 0; m_lvl[p][c] = 0;
          m_run[p][c] = 0; m_age[p][c] = 0;
        end else begin
          ks = m_s2[p][c];
          m_s2[p][c] = m_s1[p][c];
          m_s1[p][c] = int'(pk[p][c]);
          if (ks != m_lvl[p][c]) begin
            m_run[p][c]++;
            if (m_run[p][c] == G) begin
              m_run[p][c] = 0;
              m_lvl[p][c] = 1 - m_lvl[p][c];
              if (m_lvl[p][c] == 1) begin
                e_prs[p][c] = 1'b1;
                m_age[p][c] = 0;
              end else begin
                e_rel[p][c] = 1'b1;
              end
            end
          end else begin
            m_run[p][c] = 0;
          end
          if (m_lvl[p][c] == 1 && !e_prs[p][c]) begin
            m_age[p][c]++;
            if (m_age[p][c] == H ||
                (REP[p] != 0 && m_age[p][c] > H && ((m_age[p][c] - H) % R) == 0))
              e_hld[p][c] = 1'b1;
          end
        end
        e_lvl[p][c] = m_lvl[p][c][0];
      end
    end
  endtask

  // Advance one clock, then compare every DUT output against the model.
  task automatic cycle();
    @(negedge clk);
    ncyc++;
    model_step();
    for (int p = 0; p < NI; p++) begin
      chk($sformatf("level%0d", p), 32'(lvl[p]), 32'(e_lvl[p]));
      chk($sformatf("press%0d", p), 32'(prs[p]), 32'(e_prs[p]));
      chk($sformatf("release%0d", p), 32'(rel[p]), 32'(e_rel[p]));
      chk($sformatf("hold%0d", p), 32'(hld[p]), 32'(e_hld[p]));
      for (int c = 0; c < NC; c++) begin
        ev_p[p][c] += int'(prs[p][c]);
        ev_r[p][c] += int'(rel[p][c]);
        ev_h[p][c] += int'(hld[p][c]);
      end
    end
  endtask

  task automatic clear_ev();
    for (int p = 0; p < NI; p++)
      for (int c = 0; c < NC; c++) begin
        ev_p[p][c] = 0; ev_r[p][c] = 0; ev_h[p][c] = 0;
      end
  endtask

  // Bounded wait for a press (kind 0) or release (kind 1) strobe; n = edges taken.
  task automatic wait_ev(input int p, input int c, input int kind, input int maxc, output int n);
    logic hit;
    n = 0;
    do begin
      cycle();
      n++;
      hit = (kind == 0) ? prs[p][c] : rel[p][c];
    end while (!hit && n < maxc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first_off;
    int dur [NI][NC];
    int r;

    rst_n = 1'b0;
    for (int p = 0; p < NI; p++) pk[p] = '0;
    clear_ev();
    repeat (3) cycle();
    chk("reset_level", {20'd0, lvl[0], lvl[1], lvl[2]}, 32'd0);
    chk("reset_strobes", {20'd0, prs[0] | rel[0] | hld[0], prs[1] | rel[1] | hld[1],
                          prs[2] | rel[2] | hld[2]}, 32'd0);
    rst_n = 1'b1;

    // Single press on A key0: 17 edges from first sample, neighbours silent.
    pk[0][0] = 1'b1;
    wait_ev(0, 0, 0, 40, n);
    chk("press_latency", n, 17);
    chk("press_level", 32'(lvl[0]), 32'h1);
    chk("neighbours_silent", ev_p[0][1] + ev_p[0][2] + ev_p[0][3], 0);
    pk[0][0] = 1'b0;
    wait_ev(0, 0, 1, 40, n);
    chk("release_latency", n, 17);

    // Glitches of 14 cycles are rejected; 15 cycles are accepted.
    clear_ev();
    repeat (20) begin
      pk[0][1] = 1'b1; repeat (14) cycle();
      pk[0][1] = 1'b0; repeat (14) cycle();
    end
    chk("glitch_no_press", ev_p[0][1] + ev_r[0][1], 0);
    pk[0][1] = 1'b1; repeat (15) cycle();
    pk[0][1] = 1'b0; repeat (40) cycle();
    chk("min_press", ev_p[0][1], 1);
    chk("min_release", ev_r[0][1], 1);

    // Auto-repeat on A key2: holds at +150,+300,+450,+600.
    clear_ev();
    pk[0][2] = 1'b1;
    wait_ev(0, 2, 0, 40, n);
    first_off = -1;
    for (int i = 1; i <= 700; i++) begin
      cycle();
      if (hld[0][2] && first_off < 0) first_off = i;
    end
    chk("first_hold_offset", first_off, 150);
    pk[0][2] = 1'b0;
    wait_ev(0, 2, 1, 40, n);
    chk("hold_release_lat", n, 17);
    chk("repeat_count", ev_h[0][2], 4);
    chk("repeat_release_cnt", ev_r[0][2], 1);

    // No repeat on B: exactly one hold.
    clear_ev();
    pk[1][2] = 1'b1;
    wait_ev(1, 2, 0, 40, n);
    repeat (400) cycle();
    chk("single_hold", ev_h[1][2], 1);
    pk[1][2] = 1'b0;
    repeat (40) cycle();

    // Release lands on the hold edge (+150): release wins.
    clear_ev();
    pk[1][3] = 1'b1;
    wait_ev(1, 3, 0, 40, n);
    repeat (133) cycle();
    pk[1][3] = 1'b0;
    wait_ev(1, 3, 1, 40, n);
    chk("collide_release_lat", n, 17);
    repeat (5) cycle();
    chk("collide_no_hold", ev_h[1][3], 0);

    // Active-low C: idle-high keys stay silent; a 30-cycle low press is one event pair.
    clear_ev();
    repeat (20) cycle();
    chk("idle_high_silent", ev_p[2][0] + ev_p[2][1] + ev_p[2][2] + ev_p[2][3], 0);
    pk[2][3] = 1'b1; repeat (30) cycle();
    pk[2][3] = 1'b0; repeat (40) cycle();
    chk("active_low_press", ev_p[2][3], 1);
    chk("active_low_release", ev_r[2][3], 1);

    // Reset in the middle of a hold.
    pk[0][0] = 1'b1;
    wait_ev(0, 0, 0, 40, n);
    repeat (20) cycle();
    chk("held_level", 32'(lvl[0][0]), 32'h1);
    clear_ev();
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {16'd0, lvl[0], prs[0], rel[0], hld[0]}, 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    wait_ev(0, 0, 0, 40, n);
    chk("repress_latency", n, 17);
    chk("no_release_on_reset", ev_r[0][0], 0);
    pk[0][0] = 1'b0;
    repeat (40) cycle();

    // Randomised traffic on every key of every instance, with one mid-run reset.
    for (int p = 0; p < NI; p++)
      for (int c = 0; c < NC; c++) dur[p][c] = $urandom_range(1, 20);
    for (int i = 0; i < 4000; i++) begin
      for (int p = 0; p < NI; p++)
        for (int c = 0; c < NC; c++) begin
          dur[p][c]--;
          if (dur[p][c] <= 0) begin
            pk[p][c] = ~pk[p][c];
            r = $urandom_range(0, 9);
            if (r < 5)      dur[p][c] = $urandom_range(1, 16);
            else if (r < 8) dur[p][c] = $urandom_range(14, 40);
            else            dur[p][c] = $urandom_range(140, 500);
          end
        end
      if (i == 2000) rst_n = 1'b0;
      if (i == 2003) rst_n = 1'b1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
